// File: rtl/exception_unit.sv
// ----------------------------------------------------------------------------
// exception_unit
//
// Sequential exception controller placed directly after the main decoder.
// When the decoder reports an exception in IDLE, the unit:
//   - latches the faulting PC into ELR and the 4-bit cause into ESR
//   - spends one TAKE cycle redirecting fetch to the vector
//   - acknowledges the external IRQ if that IRQ caused the exception
//   - waits in HANDLER with exceptions masked
// ERET from HANDLER passes through one RET cycle, which returns fetch to ELR.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   Exc         exception request from the decoder (ExtIRQ | NotAnInstr)
//   NotAnInstr  undefined-opcode flag from the decoder
//   EStatus     decoder cause code, meaningful only when NotAnInstr=1
//   ERet        ERET decoded
//   ExtIRQ      level-sensitive external interrupt, held until ExtIAck
//   PC_in       PC of the instruction currently in decode
//   exc_take    1-cycle pulse: flush pipe, load PC with exc_vector
//   exc_vector  constant exception vector
//   ret_valid   1-cycle pulse: load PC with ret_pc
//   ret_pc      return address (mirrors ELR)
//   ExtIAck     1-cycle pulse acknowledging an accepted IRQ
//   ELR         exception link register
//   ESR         exception syndrome register (zero-extended 4-bit cause)
//   in_handler  high in TAKE and HANDLER (exceptions masked)
//   dbl_fault   sticky flag: undefined opcode seen while masked
// ----------------------------------------------------------------------------
module exception_unit #(
    parameter int          N           = 64,
    parameter logic [63:0] VECTOR_ADDR = 64'hD8,
    parameter logic [3:0]  IRQ_CODE    = 4'b0001
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Exc,
    input  logic         NotAnInstr,
    input  logic [3:0]   EStatus,
    input  logic         ERet,
    input  logic         ExtIRQ,
    input  logic [N-1:0] PC_in,
    output logic         exc_take,
    output logic [N-1:0] exc_vector,
    output logic         ret_valid,
    output logic [N-1:0] ret_pc,
    output logic         ExtIAck,
    output logic [N-1:0] ELR,
    output logic [N-1:0] ESR,
    output logic         in_handler,
    output logic         dbl_fault
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        HANDLER = 2'd2,
        RET     = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   elr;
    logic [3:0]     esr;
    logic           irq_taken;
    logic           dbl;
    logic [3:0]     cause;

    // An undefined opcode outranks the interrupt; a losing IRQ stays pending
    // because the source keeps the line high until it is acknowledged.
    assign cause = NotAnInstr ? EStatus : IRQ_CODE;

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the values present before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            elr       <= '0;
            esr       <= '0;
            irq_taken <= 1'b0;
            dbl       <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && Exc) begin
                elr       <= PC_in;
                esr       <= cause;
                // Only a real, winning IRQ line is ever acknowledged.
                irq_taken <= ExtIRQ && !NotAnInstr;
            end
            if (state == HANDLER && NotAnInstr) begin
                dbl <= 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        exc_take   = 1'b0;
        ExtIAck    = 1'b0;
        ret_valid  = 1'b0;
        in_handler = 1'b0;
        unique case (state)
            IDLE: begin
                // ERet is deliberately ignored here.
                if (Exc) state_next = TAKE;
            end
            TAKE: begin
                exc_take   = 1'b1;
                ExtIAck    = irq_taken;
                in_handler = 1'b1;
                state_next = HANDLER;
            end
            HANDLER: begin
                in_handler = 1'b1;
                if (ERet) state_next = RET;
            end
            RET: begin
                ret_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign exc_vector = N'(VECTOR_ADDR);
    assign ELR        = elr;
    assign ret_pc     = elr;
    assign ESR        = {{(N-4){1'b0}}, esr};
    assign dbl_fault  = dbl;

endmodule

// File: tb/tb_exception_unit.sv
// ----------------------------------------------------------------------------
// tb_exception_unit
//
// Directed self-checking bench for exception_unit. Inputs change 1 ns after a
// rising edge and outputs are sampled at that same point, well away from the
// active edge. Expected values are written out by hand in each scenario.
// ----------------------------------------------------------------------------
module tb_exception_unit;

    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic         Exc;
    logic         NotAnInstr;
    logic [3:0]   EStatus;
    logic         ERet;
    logic         ExtIRQ;
    logic [N-1:0] PC_in;
    logic         exc_take;
    logic [N-1:0] exc_vector;
    logic         ret_valid;
    logic [N-1:0] ret_pc;
    logic         ExtIAck;
    logic [N-1:0] ELR;
    logic [N-1:0] ESR;
    logic         in_handler;
    logic         dbl_fault;

    int checks = 0;
    int errors = 0;

    exception_unit #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .Exc        (Exc),
        .NotAnInstr (NotAnInstr),
        .EStatus    (EStatus),
        .ERet       (ERet),
        .ExtIRQ     (ExtIRQ),
        .PC_in      (PC_in),
        .exc_take   (exc_take),
        .exc_vector (exc_vector),
        .ret_valid  (ret_valid),
        .ret_pc     (ret_pc),
        .ExtIAck    (ExtIAck),
        .ELR        (ELR),
        .ESR        (ESR),
        .in_handler (in_handler),
        .dbl_fault  (dbl_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Exc        = 1'b0;
        NotAnInstr = 1'b0;
        EStatus    = 4'd0;
        ERet       = 1'b0;
        ExtIRQ     = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        PC_in = '0;

        // Reset state
        #12;
        check("rst_elr",        ELR,        64'h0);
        check("rst_esr",        ESR,        64'h0);
        check("rst_in_handler", in_handler, 1'b0);
        check("rst_dbl",        dbl_fault,  1'b0);
        check("rst_exc_take",   exc_take,   1'b0);
        check("rst_ret_valid",  ret_valid,  1'b0);
        check("rst_ack",        ExtIAck,    1'b0);
        check("vector",         exc_vector, 64'hD8);
        step();
        reset = 1'b1;
        step();
        check("idle_in_handler", in_handler, 1'b0);

        // 1: undefined opcode
        Exc = 1'b1; NotAnInstr = 1'b1; EStatus = 4'd2; PC_in = 64'h40;
        step();
        check("t1_exc_take",   exc_take,   1'b1);
        check("t1_elr",        ELR,        64'h40);
        check("t1_esr",        ESR,        64'h2);
        check("t1_ack",        ExtIAck,    1'b0);
        check("t1_in_handler", in_handler, 1'b1);
        idle_inputs(); PC_in = 64'h44;
        step();
        check("t1_hnd_take",   exc_take,   1'b0);
        check("t1_hnd_inh",    in_handler, 1'b1);
        ERet = 1'b1;
        step();
        check("t1_ret_valid",  ret_valid,  1'b1);
        check("t1_ret_pc",     ret_pc,     64'h40);
        check("t1_ret_take",   exc_take,   1'b0);
        check("t1_ret_inh",    in_handler, 1'b0);
        ERet = 1'b0;
        step();
        check("t1_idle_ret",   ret_valid,  1'b0);
        check("t1_dbl",        dbl_fault,  1'b0);

        // 2: external interrupt
        Exc = 1'b1; ExtIRQ = 1'b1; PC_in = 64'h80;
        step();
        check("t2_exc_take",   exc_take,   1'b1);
        check("t2_esr",        ESR,        64'h1);
        check("t2_elr",        ELR,        64'h80);
        check("t2_ack",        ExtIAck,    1'b1);
        idle_inputs();
        step();
        check("t2_ack_once",   ExtIAck,    1'b0);
        check("t2_hnd_take",   exc_take,   1'b0);
        ERet = 1'b1;
        step();
        check("t2_ret_valid",  ret_valid,  1'b1);
        check("t2_ret_pc",     ret_pc,     64'h80);
        ERet = 1'b0;
        step();
        check("t2_idle_ret",   ret_valid,  1'b0);
        check("t2_idle_inh",   in_handler, 1'b0);
        check("t2_idle_take",  exc_take,   1'b0);

        // 3: simultaneous undefined opcode and IRQ; IRQ taken after return
        Exc = 1'b1; NotAnInstr = 1'b1; ExtIRQ = 1'b1; EStatus = 4'd2; PC_in = 64'h10;
        step();
        check("t3_exc_take",   exc_take,   1'b1);
        check("t3_esr",        ESR,        64'h2);
        check("t3_elr",        ELR,        64'h10);
        check("t3_no_ack",     ExtIAck,    1'b0);
        NotAnInstr = 1'b0; EStatus = 4'd0;
        step();
        check("t3_hnd_take",   exc_take,   1'b0);
        check("t3_hnd_ack",    ExtIAck,    1'b0);
        ERet = 1'b1;
        step();
        check("t3_ret_valid",  ret_valid,  1'b1);
        check("t3_ret_pc",     ret_pc,     64'h10);
        check("t3_ret_ack",    ExtIAck,    1'b0);
        ERet = 1'b0; PC_in = 64'h14;
        step();
        check("t3_idle_take",  exc_take,   1'b0);
        check("t3_idle_ret",   ret_valid,  1'b0);
        step();
        check("t3_irq_take",   exc_take,   1'b1);
        check("t3_irq_esr",    ESR,        64'h1);
        check("t3_irq_elr",    ELR,        64'h14);
        check("t3_irq_ack",    ExtIAck,    1'b1);
        idle_inputs();
        step();
        check("t3_ack_once",   ExtIAck,    1'b0);

        // 4: masking in HANDLER, then double fault
        Exc = 1'b1; ExtIRQ = 1'b1; PC_in = 64'h99;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_mask_take", exc_take,   1'b0);
            check("t4_mask_ack",  ExtIAck,    1'b0);
            check("t4_mask_inh",  in_handler, 1'b1);
        end
        check("t4_elr_frozen", ELR,       64'h14);
        check("t4_esr_frozen", ESR,       64'h1);
        check("t4_dbl_before", dbl_fault, 1'b0);
        ExtIRQ = 1'b0; NotAnInstr = 1'b1; EStatus = 4'd5;
        step();
        check("t4_dbl_set",    dbl_fault, 1'b1);
        check("t4_esr_keep",   ESR,       64'h1);
        check("t4_dbl_take",   exc_take,  1'b0);
        idle_inputs();
        step();
        check("t4_dbl_sticky", dbl_fault, 1'b1);
        ERet = 1'b1;
        step();
        check("t4_ret_valid",  ret_valid, 1'b1);
        ERet = 1'b0;
        step();
        check("t4_dbl_idle",   dbl_fault, 1'b1);

        // 5: ERet in IDLE is ignored
        ERet = 1'b1;
        step();
        check("t5_ret_valid",  ret_valid,  1'b0);
        check("t5_inh",        in_handler, 1'b0);
        check("t5_take",       exc_take,   1'b0);
        step();
        check("t5_ret_valid2", ret_valid,  1'b0);
        ERet = 1'b0;

        // 6: asynchronous reset in the middle of HANDLER
        Exc = 1'b1; NotAnInstr = 1'b1; EStatus = 4'd3; PC_in = 64'h20;
        step();
        check("t6_take",       exc_take,   1'b1);
        check("t6_esr",        ESR,        64'h3);
        idle_inputs();
        step();
        check("t6_in_handler", in_handler, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        check("t6_rst_elr",    ELR,        64'h0);
        check("t6_rst_esr",    ESR,        64'h0);
        check("t6_rst_inh",    in_handler, 1'b0);
        check("t6_rst_dbl",    dbl_fault,  1'b0);
        check("t6_rst_ack",    ExtIAck,    1'b0);
        check("t6_rst_ret",    ret_valid,  1'b0);
        step();
        reset = 1'b1;
        ERet = 1'b1;
        step();
        check("t6_post_ret",   ret_valid,  1'b0);
        check("t6_post_inh",   in_handler, 1'b0);
        ERet = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
